wb_writer: RTL and testbench
============================

# wb_writer

Writeback writer for the MIPS core register file: merges results from the single-cycle ALU path and the multi-cycle multiply/divide unit onto the file's one write port (`regWrite`, `wrAddr`, `wrData`). ALU results have fixed priority. Mul/div results are buffered in a small FIFO. A per-register pending scoreboard lets issue logic stall on outstanding mul/div destinations. Writes to register 0 are suppressed here, so `$zero` stays 0.

## Interface
- `DEPTH`, 2: mul/div result FIFO entries; power of two, ≥2.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `aluValid`  in  1: ALU result valid this cycle; no backpressure, always accepted.
- `aluAddr`  in  5: ALU destination register.
- `aluData`  in  32: ALU result.
- `mdValid`  in  1: mul/div result offered.
- `mdReady`  out  1: FIFO can accept; transfer when `mdValid && mdReady`.
- `mdAddr`  in  5: mul/div destination.
- `mdData`  in  32: mul/div result.
- `rsvValid`  in  1: issue logic reserves a mul/div destination.
- `rsvAddr`  in  5: register to mark pending.
- `pending`  out  32: bit i = outstanding mul/div write to register i; bit 0 is always 0.
- `regWrite`  out  1: to register file write enable.
- `wrAddr`  out  5: to register file write address.
- `wrData`  out  32: to register file write data.

## Operation
- Reset (synchronous, held high): FIFO empty, `pending` = 0, `regWrite` = 0, `wrAddr` = 0, `wrData` = 0, `mdReady` = 0.
- `mdReady` = !reset && (FIFO count < DEPTH). It is derived from the registered count only, with no same-cycle pop lookahead.
- A push stores {mdAddr, mdData} at the tail. A push with `mdAddr` = 0 is accepted and discarded; it does not occupy an entry.
- Arbitration each cycle:
  - Winner 1: `aluValid && aluAddr != 0`.
  - Winner 2, otherwise: the FIFO head if the FIFO is non-empty; the head is popped.
  - An ALU request to r0 is dropped and does not block the FIFO.
- Output registers load the winner: `regWrite` = 1 with its addr and data. With no winner, `regWrite` = 0 and `wrAddr`/`wrData` hold their previous values.
- Simultaneous push and pop on a non-full FIFO: both happen, and count is unchanged.
- Push when empty: the entry is not eligible for a pop in the same cycle; it becomes the head next cycle.
- Scoreboard:
  - `rsvValid && rsvAddr != 0` sets `pending[rsvAddr]` at the next edge.
  - A pending bit clears on the edge that ends a cycle where `regWrite` = 1 from the FIFO source with that address. This is the same edge on which the register file captures the data.
  - ALU writes never clear pending bits.
  - Set and clear of the same bit on the same edge: set wins.
- Counters are log2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH.

## Timing
- ALU path: input in cycle N gives `regWrite` = 1 in cycle N+1, and the register file is updated at the end of N+1.
- Mul/div path: push in cycle N gives `regWrite` no earlier than cycle N+2 (if ALU is idle in N+1). Each ALU-busy cycle adds one cycle.
- `pending` drops one cycle after the corresponding `regWrite` cycle. Readers therefore never see pending = 0 while the register file still holds stale data.
- Throughput: one write per cycle. The FIFO drains one entry per ALU-idle cycle.
- Reset mid-operation: FIFO contents and pending bits are discarded, and no write is issued in the cycle after reset.

## Test plan
- **ALU passthrough.** Stimulus: `aluValid`=1, `aluAddr`=5, `aluData`=0xDEADBEEF in cycle 3. Required: `regWrite`=1, `wrAddr`=5, `wrData`=0xDEADBEEF in cycle 4 only.
- **r0 suppression.** Stimulus: ALU write to r0, and a push of mdAddr=0. Required: `regWrite` never asserts and FIFO count stays 0. Stimulus: rsvAddr=0. Required: `pending` = 0.
- **Priority and drain.** Stimulus: push mdAddr=7/0x11; ALU writes r1..r3 on the next 3 cycles. Required: three ALU writes in order, then r7=0x11 in the 4th write cycle.
- **Full backpressure (DEPTH=2).** Stimulus: keep the ALU busy and push 3 results with `mdValid` held. Required: `mdReady`=0 after 2 accepts; the 3rd is accepted only after the first pop; all 3 written in push order.
- **Scoreboard.** Stimulus: reserve r9 at cycle 2 and push r9/0x55. Required: `pending[9]`=1 from cycle 3. Required: it drops the cycle after `regWrite` for r9. Stimulus: re-reserve r9 on the clear edge. Required: `pending[9]` stays 1.
- **Reset mid-operation.** Stimulus: 2 entries queued and `pending[4]`=1, then pulse reset for 1 cycle. Required: all outputs 0 during reset, no writes afterwards, and `mdReady`=1 from the first cycle after reset.

Source files
------------

// File: rtl/wb_writer_if.sv
// Register-file writeback bundle: ALU and mul/div result channels, the pending
// scoreboard and the single register-file write port.
interface wb_writer_if;
  logic        aluValid;
  logic [4:0]  aluAddr;
  logic [31:0] aluData;
  logic        mdValid;
  logic        mdReady;
  logic [4:0]  mdAddr;
  logic [31:0] mdData;
  logic        rsvValid;
  logic [4:0]  rsvAddr;
  logic [31:0] pending;
  logic        regWrite;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;

  modport master (
    output aluValid, aluAddr, aluData,
    output mdValid, mdAddr, mdData,
    output rsvValid, rsvAddr,
    input  mdReady, pending, regWrite, wrAddr, wrData
  );

  modport slave (
    input  aluValid, aluAddr, aluData,
    input  mdValid, mdAddr, mdData,
    input  rsvValid, rsvAddr,
    output mdReady, pending, regWrite, wrAddr, wrData
  );
endinterface

// File: rtl/wb_writer.sv
// Merges ALU results (fixed priority) and FIFO-buffered mul/div results onto
// one register-file write port, and tracks pending mul/div destinations.
module wb_writer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  wb_writer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          reg_write;
  logic          from_fifo;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   pending;
  logic [31:0]   pending_next;

  logic          md_ready;
  logic          push;
  logic          alu_win;
  logic          pop;

  // Pop decision uses the registered count, so a fresh push is never popped
  // in the same cycle it arrives.
  always_comb begin
    md_ready = !reset && (count < CW'(DEPTH));
    push     = bus.mdValid && md_ready && (bus.mdAddr != '0);
    alu_win  = bus.aluValid && (bus.aluAddr != '0);
    pop      = !alu_win && (count != '0);
  end

  // Clear first, then set, so a same-edge reservation survives the clear.
  always_comb begin
    pending_next = pending;
    if (reg_write && from_fifo) pending_next[wr_addr] = 1'b0;
    if (bus.rsvValid && (bus.rsvAddr != '0)) pending_next[bus.rsvAddr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.mdAddr;
      fifo_data[wr_ptr] <= bus.mdData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      reg_write <= 1'b0;
      from_fifo <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pending   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      reg_write <= alu_win || pop;
      from_fifo <= pop;
      if (alu_win) begin
        wr_addr <= bus.aluAddr;
        wr_data <= bus.aluData;
      end else if (pop) begin
        wr_addr <= fifo_addr[rd_ptr];
        wr_data <= fifo_data[rd_ptr];
      end

      pending <= pending_next;
    end
  end

  assign bus.mdReady  = md_ready;
  assign bus.pending  = pending;
  assign bus.regWrite = reg_write;
  assign bus.wrAddr   = wr_addr;
  assign bus.wrData   = wr_data;
endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: expected register-file writes are queued as
// stimulus is issued and checked by an independent write-port monitor.
module tb_wb_writer;
  logic clk = 1'b0;
  logic reset;

  wb_writer_if bus ();

  wb_writer #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int n_vec   = 0;
  int n_err   = 0;
  int mon_vec = 0;
  int mon_err = 0;

  // Write-port monitor: every regWrite must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.regWrite === 1'b1) begin
      mon_vec++;
      if (exp_q.size() == 0) begin
        mon_err++;
        $display("FAIL unexpected_write: got r%0d=%h, required no write", bus.wrAddr, bus.wrData);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.wrAddr !== mon_e.a || bus.wrData !== mon_e.d) begin
          mon_err++;
          $display("FAIL write_port: got r%0d=%h, required r%0d=%h",
                   bus.wrAddr, bus.wrData, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle();
    bus.aluValid = 1'b0; bus.aluAddr = '0; bus.aluData = '0;
    bus.mdValid  = 1'b0; bus.mdAddr  = '0; bus.mdData  = '0;
    bus.rsvValid = 1'b0; bus.rsvAddr = '0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.aluValid = 1'b1; bus.aluAddr = a; bus.aluData = d;
  endtask

  task automatic md(input logic [4:0] a, input logic [31:0] d);
    bus.mdValid = 1'b1; bus.mdAddr = a; bus.mdData = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    // Reset state
    chk("rst_regWrite", 32'(bus.regWrite), 32'd0);
    chk("rst_wrAddr",   32'(bus.wrAddr),   32'd0);
    chk("rst_wrData",   bus.wrData,        32'd0);
    chk("rst_mdReady",  32'(bus.mdReady),  32'd0);
    chk("rst_pending",  bus.pending,       32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_mdReady", 32'(bus.mdReady), 32'd1);

    // ALU passthrough
    step();
    exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    alu(5'd5, 32'hDEADBEEF);
    step();
    idle();
    chk("alu_regWrite_n1", 32'(bus.regWrite), 32'd1);
    step();
    chk("alu_regWrite_n2", 32'(bus.regWrite), 32'd0);

    // r0 suppression on every source
    alu(5'd0, 32'h12345678);
    md(5'd0, 32'h87654321);
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd0;
    step();
    idle();
    step();
    chk("r0_regWrite", 32'(bus.regWrite), 32'd0);
    chk("r0_fifo_count", 32'(dut.count), 32'd0);
    chk("r0_pending", bus.pending, 32'd0);

    // Priority and drain
    exp_q.push_back('{a: 5'd1, d: 32'h0000_0101});
    exp_q.push_back('{a: 5'd2, d: 32'h0000_0202});
    exp_q.push_back('{a: 5'd3, d: 32'h0000_0303});
    exp_q.push_back('{a: 5'd7, d: 32'h0000_0011});
    md(5'd7, 32'h11);
    step();
    idle(); alu(5'd1, 32'h101); step();
    idle(); alu(5'd2, 32'h202); step();
    idle(); alu(5'd3, 32'h303); step();
    idle(); step();
    chk("drain_wrAddr", 32'(bus.wrAddr), 32'd7);
    step();
    chk("drain_idle", 32'(bus.regWrite), 32'd0);

    // Full backpressure, DEPTH=2, ALU held busy
    exp_q.push_back('{a: 5'd10, d: 32'h0000_010A});
    exp_q.push_back('{a: 5'd11, d: 32'h0000_010B});
    exp_q.push_back('{a: 5'd12, d: 32'h0000_010C});
    exp_q.push_back('{a: 5'd20, d: 32'h0000_00A0});
    exp_q.push_back('{a: 5'd21, d: 32'h0000_00B0});
    exp_q.push_back('{a: 5'd22, d: 32'h0000_00C0});
    chk("bp_ready_c0", 32'(bus.mdReady), 32'd1);
    alu(5'd10, 32'h10A); md(5'd20, 32'hA0); step();
    chk("bp_ready_c1", 32'(bus.mdReady), 32'd1);
    alu(5'd11, 32'h10B); md(5'd21, 32'hB0); step();
    chk("bp_ready_c2", 32'(bus.mdReady), 32'd0);
    alu(5'd12, 32'h10C); md(5'd22, 32'hC0); step();
    chk("bp_ready_c3", 32'(bus.mdReady), 32'd0);
    bus.aluValid = 1'b0; step();
    chk("bp_ready_c4", 32'(bus.mdReady), 32'd1);
    step();
    idle();
    step();
    step();
    step();

    // Scoreboard: set, hold through the write cycle, clear after
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd9;
    step();
    idle();
    chk("sb_set", 32'(bus.pending[9]), 32'd1);
    exp_q.push_back('{a: 5'd9, d: 32'h0000_0055});
    md(5'd9, 32'h55);
    step();
    idle();
    chk("sb_hold_queued", 32'(bus.pending[9]), 32'd1);
    step();
    chk("sb_write_cycle", 32'(bus.regWrite), 32'd1);
    chk("sb_hold_write", 32'(bus.pending[9]), 32'd1);
    step();
    chk("sb_clear", 32'(bus.pending[9]), 32'd0);

    // Scoreboard: re-reserve on the clearing edge keeps the bit set
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd9;
    step();
    idle();
    exp_q.push_back('{a: 5'd9, d: 32'h0000_0066});
    md(5'd9, 32'h66);
    step();
    idle();
    step();
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd9;
    step();
    idle();
    chk("sb_set_wins", 32'(bus.pending[9]), 32'd1);

    // Reset mid-operation with two queued entries
    exp_q.push_back('{a: 5'd12, d: 32'h0000_0C12});
    exp_q.push_back('{a: 5'd14, d: 32'h0000_0C14});
    alu(5'd12, 32'hC12); md(5'd13, 32'h13);
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd4;
    step();
    idle();
    chk("mid_pending4", 32'(bus.pending[4]), 32'd1);
    alu(5'd14, 32'hC14); md(5'd15, 32'h15);
    step();
    idle();
    chk("mid_queued", 32'(dut.count), 32'd2);
    reset = 1'b1;
    step();
    chk("mid_rst_regWrite", 32'(bus.regWrite), 32'd0);
    chk("mid_rst_wrAddr",   32'(bus.wrAddr),   32'd0);
    chk("mid_rst_wrData",   bus.wrData,        32'd0);
    chk("mid_rst_mdReady",  32'(bus.mdReady),  32'd0);
    chk("mid_rst_pending",  bus.pending,       32'd0);
    reset = 1'b0;
    #1;
    chk("mid_post_mdReady", 32'(bus.mdReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_post_regWrite", 32'(bus.regWrite), 32'd0);
    end
    chk("mid_post_count", 32'(dut.count), 32'd0);

    step();
    chk("expected_writes_left", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec + mon_vec, n_err + mon_err);
    $finish;
  end
endmodule
